// File: rtl/dram_write_bridge.sv
`timescale 1ns/1ps
// dram_write_bridge
// Buffers packed DRAM write beats and commands in two show-ahead FIFOs and
// turns each command into one AXI4 INCR write burst. A burst is launched only
// when its whole payload is already buffered, so W never starves mid-burst.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   data_in[35:0]/data_we write beat push: [35:32] strobe, [31:0] data
//   ctrl_in[39:0]/ctrl_we command push: [39:32] beat count, [31:0] byte address
//   m_axi_aw*             AXI4 write address channel (size 4 B, INCR)
//   m_axi_w*              AXI4 write data channel
//   m_axi_b*              AXI4 write response channel
//   busy                  commands queued, burst in flight, or responses pending
//   overflow              sticky: a push was dropped on a full FIFO
//   cmd_err               sticky: a zero-length command was received
//   resp_err              sticky: a non-OKAY write response was seen
module dram_write_bridge #(
    parameter int unsigned DATA_AW         = 8,
    parameter int unsigned CMD_AW          = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [35:0] data_in,
    input  logic        data_we,
    input  logic [39:0] ctrl_in,
    input  logic        ctrl_we,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        busy,
    output logic        overflow,
    output logic        cmd_err,
    output logic        resp_err
);

    localparam int unsigned DATA_DEPTH = 1 << DATA_AW;
    localparam int unsigned CMD_DEPTH  = 1 << CMD_AW;
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2
    } state_t;

    state_t state, state_d;

    // Data FIFO (show-ahead)
    logic [35:0]        data_mem [DATA_DEPTH];
    logic [DATA_AW-1:0] data_rd_ptr, data_wr_ptr, data_rd_nxt;
    logic [DATA_AW:0]   data_count, data_count_d;
    logic               data_full, data_push, data_pop;
    logic [35:0]        data_head, data_next;

    // Command FIFO (show-ahead)
    logic [39:0]        cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0]  cmd_rd_ptr, cmd_wr_ptr;
    logic [CMD_AW:0]    cmd_count, cmd_count_d;
    logic               cmd_full, cmd_push, cmd_pop, cmd_zero_len;
    logic [39:0]        cmd_head;
    logic [7:0]         head_len;

    logic [OUT_W-1:0]   outstanding, outstanding_d;
    logic [7:0]         beats_left;
    logic               aw_hs, w_hs, b_hs, busy_d;

    assign m_axi_awsize  = 3'd2;
    assign m_axi_awburst = 2'b01;

    assign data_full   = (data_count == (DATA_AW+1)'(DATA_DEPTH));
    assign data_push   = data_we && !data_full;
    assign data_pop    = w_hs;
    assign data_rd_nxt = data_rd_ptr + DATA_AW'(1);
    assign data_head   = data_mem[data_rd_ptr];
    // Entry behind the head, preloaded into the W register as each beat retires
    assign data_next   = data_mem[data_rd_nxt];

    assign cmd_zero_len = (ctrl_in[39:32] == 8'd0);
    assign cmd_full     = (cmd_count == (CMD_AW+1)'(CMD_DEPTH));
    assign cmd_push     = ctrl_we && !cmd_full && !cmd_zero_len;
    assign cmd_head     = cmd_mem[cmd_rd_ptr];
    assign head_len     = cmd_head[39:32];

    assign b_hs = m_axi_bvalid && m_axi_bready;

    // FIFO storage
    always_ff @(posedge CLK) begin
        if (data_push) data_mem[data_wr_ptr] <= data_in;
        if (cmd_push)  cmd_mem[cmd_wr_ptr]   <= ctrl_in;
    end

    // FIFO pointers and occupancy; fullness is judged before any same-cycle pop
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_rd_ptr <= '0;
            data_wr_ptr <= '0;
            data_count  <= '0;
            cmd_rd_ptr  <= '0;
            cmd_wr_ptr  <= '0;
            cmd_count   <= '0;
        end else begin
            if (data_push) data_wr_ptr <= data_wr_ptr + DATA_AW'(1);
            if (data_pop)  data_rd_ptr <= data_rd_nxt;
            if (cmd_push)  cmd_wr_ptr  <= cmd_wr_ptr + CMD_AW'(1);
            if (cmd_pop)   cmd_rd_ptr  <= cmd_rd_ptr + CMD_AW'(1);
            data_count <= data_count_d;
            cmd_count  <= cmd_count_d;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Next state, handshake strobes, outstanding and busy bookkeeping
    always_comb begin
        state_d       = state;
        cmd_pop       = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        outstanding_d = outstanding;

        unique case (state)
            ST_IDLE: begin
                if ((cmd_count != '0) &&
                    (32'(data_count) >= 32'(head_len)) &&
                    (outstanding < OUT_W'(MAX_OUTSTANDING))) begin
                    cmd_pop = 1'b1;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    aw_hs   = 1'b1;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (m_axi_wready) begin
                    w_hs = 1'b1;
                    if (beats_left == 8'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A same-cycle AW handshake and B response cancel out
        if (aw_hs && !b_hs) begin
            outstanding_d = outstanding + OUT_W'(1);
        end else if (!aw_hs && b_hs && (outstanding != '0)) begin
            outstanding_d = outstanding - OUT_W'(1);
        end

        data_count_d = data_count + (DATA_AW+1)'(data_push) - (DATA_AW+1)'(data_pop);
        cmd_count_d  = cmd_count + (CMD_AW+1)'(cmd_push) - (CMD_AW+1)'(cmd_pop);
        busy_d       = (cmd_count_d != '0) || (state_d != ST_IDLE) || (outstanding_d != '0);
    end

    // Registered AXI outputs and status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wlast   <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            beats_left    <= '0;
            outstanding   <= '0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            cmd_err       <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            m_axi_bready <= 1'b1;
            outstanding  <= outstanding_d;
            busy         <= busy_d;

            if (cmd_pop) begin
                m_axi_awaddr  <= cmd_head[31:0] & 32'hFFFF_FFFC;
                m_axi_awlen   <= head_len - 8'd1;
                m_axi_awvalid <= 1'b1;
            end

            // First beat is presented straight from the FIFO head
            if (aw_hs) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b1;
                m_axi_wdata   <= data_head[31:0];
                m_axi_wstrb   <= data_head[35:32];
                m_axi_wlast   <= (m_axi_awlen == 8'd0);
                beats_left    <= m_axi_awlen + 8'd1;
            end

            if (w_hs) begin
                beats_left <= beats_left - 8'd1;
                if (beats_left == 8'd1) begin
                    m_axi_wvalid <= 1'b0;
                    m_axi_wlast  <= 1'b0;
                end else begin
                    m_axi_wdata <= data_next[31:0];
                    m_axi_wstrb <= data_next[35:32];
                    m_axi_wlast <= (beats_left == 8'd2);
                end
            end

            if ((data_we && data_full) || (ctrl_we && !cmd_zero_len && cmd_full)) overflow <= 1'b1;
            if (ctrl_we && cmd_zero_len)                                          cmd_err  <= 1'b1;
            if (b_hs && (m_axi_bresp != 2'b00))                                   resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_write_bridge.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for dram_write_bridge. Stimulus tasks feed a
// queue-based reference model that predicts AW requests and W beats; a
// negedge monitor compares every handshake against the predictions.
module tb_dram_write_bridge;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [35:0] data_in = '0;
    logic        data_we = 1'b0;
    logic [39:0] ctrl_in = '0;
    logic        ctrl_we = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic        busy, overflow, cmd_err, resp_err;

    dram_write_bridge #(.DATA_AW(8), .CMD_AW(4), .MAX_OUTSTANDING(4)) dut (
        .CLK(CLK), .RST(RST),
        .data_in(data_in), .data_we(data_we), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy), .overflow(overflow), .cmd_err(cmd_err), .resp_err(resp_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
    typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } dbeat_t;
    typedef struct packed { logic [7:0] len; logic [31:0] addr; } cmd_t;

    wbeat_t exp_w[$];
    aw_t    exp_aw[$];
    dbeat_t pool[$];
    cmd_t   pend[$];

    int checks = 0;
    int errors = 0;
    int aw_count = 0, w_count = 0, wlast_count = 0, b_count = 0;
    int b_sent = 0, accepted = 0;
    int b_budget = 1000000;
    logic [1:0] b_resp_val = 2'b00;
    int aw_pct = 100, w_pct = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: each command claims the next len beats in push order
    function automatic void model_advance();
        while (pend.size() > 0 && pool.size() >= int'(pend[0].len)) begin
            cmd_t c;
            c = pend.pop_front();
            exp_aw.push_back('{addr: c.addr & 32'hFFFF_FFFC, len: c.len - 8'd1});
            for (int i = 0; i < int'(c.len); i++) begin
                dbeat_t d;
                d = pool.pop_front();
                exp_w.push_back('{data: d.data, strb: d.strb, last: (i == int'(c.len) - 1)});
            end
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_data(input logic [31:0] d, input logic [3:0] s);
        data_in = {s, d};
        data_we = 1'b1;
        // Occupancy seen by this push: accepted minus beats already drained
        if (accepted - w_count < 256) begin
            accepted++;
            pool.push_back('{data: d, strb: s});
            model_advance();
        end
        tick();
        data_we = 1'b0;
    endtask

    task automatic push_cmd(input logic [7:0] len, input logic [31:0] addr);
        ctrl_in = {len, addr};
        ctrl_we = 1'b1;
        if (len != 8'd0) begin
            pend.push_back('{len: len, addr: addr});
            model_advance();
        end
        tick();
        ctrl_we = 1'b0;
    endtask

    task automatic expect_aw_after(input string name, input int exp_n);
        int n;
        n = 0;
        while (n < 8) begin
            @(negedge CLK);
            n++;
            if (m_axi_awvalid) break;
        end
        check(name, 64'(n), 64'(exp_n));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 5000 && !(exp_aw.size() == 0 && exp_w.size() == 0 && b_count == wlast_count)) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_timeout"}, 64'(n >= 5000), 64'(0));
        @(negedge CLK);
        check({name, "_busy_low"}, 64'(busy), 64'(0));
    endtask

    task automatic single_burst(input string name);
        for (int i = 0; i < 64; i++) push_data(32'(i), 4'hF);
        push_cmd(8'd64, 32'h1000_0004);
        expect_aw_after({name, "_aw_latency"}, 2);
        check({name, "_busy_high"}, 64'(busy), 64'(1));
        wait_idle(name);
    endtask

    // Ready drivers
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            m_axi_awready = ($urandom_range(99) < aw_pct);
            m_axi_wready  = ($urandom_range(99) < w_pct);
        end
    end

    // B responder: one response per completed burst, limited by b_budget
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                b_sent       = 0;
                m_axi_bvalid = 1'b0;
            end else if (b_budget > 0 && wlast_count > b_sent) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = b_resp_val;
                b_sent++;
                b_budget--;
            end else begin
                m_axi_bvalid = 1'b0;
                m_axi_bresp  = 2'b00;
            end
        end
    end

    // Monitor: values seen at negedge are those taken at the following posedge
    aw_t         m_aw;
    wbeat_t      m_w;
    logic        aw_stall = 1'b0, w_stall = 1'b0;
    logic [39:0] prev_aw;
    logic [36:0] prev_w;

    always @(negedge CLK) begin
        if (RST) begin
            aw_count = 0; w_count = 0; wlast_count = 0; b_count = 0;
            aw_stall = 1'b0; w_stall = 1'b0;
        end else begin
            if (aw_stall)
                check("aw_hold", 64'({m_axi_awvalid, m_axi_awaddr, m_axi_awlen}), 64'({1'b1, prev_aw}));
            if (w_stall)
                check("w_hold", 64'({m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast}), 64'({1'b1, prev_w}));
            if (m_axi_awvalid && m_axi_awready) begin
                aw_count++;
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected", 64'(1), 64'(0));
                end else begin
                    m_aw = exp_aw.pop_front();
                    check("awaddr", 64'(m_axi_awaddr), 64'(m_aw.addr));
                    check("awlen", 64'(m_axi_awlen), 64'(m_aw.len));
                    check("awsize", 64'(m_axi_awsize), 64'(2));
                    check("awburst", 64'(m_axi_awburst), 64'(1));
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("w_after_aw", 64'(aw_count > wlast_count), 64'(1));
                w_count++;
                if (exp_w.size() == 0) begin
                    check("w_unexpected", 64'(1), 64'(0));
                end else begin
                    m_w = exp_w.pop_front();
                    check("wdata", 64'(m_axi_wdata), 64'(m_w.data));
                    check("wstrb", 64'(m_axi_wstrb), 64'(m_w.strb));
                    check("wlast", 64'(m_axi_wlast), 64'(m_w.last));
                end
                if (m_axi_wlast) wlast_count++;
            end
            if (m_axi_bvalid && m_axi_bready) b_count++;
            aw_stall = m_axi_awvalid && !m_axi_awready;
            prev_aw  = {m_axi_awaddr, m_axi_awlen};
            w_stall  = m_axi_wvalid && !m_axi_wready;
            prev_w   = {m_axi_wdata, m_axi_wstrb, m_axi_wlast};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int   n, aw0, b0, w0;

        // Reset state
        repeat (3) tick();
        @(negedge CLK);
        check("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
        check("rst_wvalid", 64'(m_axi_wvalid), 64'(0));
        check("rst_wlast", 64'(m_axi_wlast), 64'(0));
        check("rst_bready", 64'(m_axi_bready), 64'(0));
        check("rst_aw_fields", 64'({m_axi_awaddr, m_axi_awlen}), 64'(0));
        check("rst_w_fields", 64'({m_axi_wdata, m_axi_wstrb}), 64'(0));
        check("rst_status", 64'({busy, overflow, cmd_err, resp_err}), 64'(0));
        tick();
        RST = 1'b0;
        tick();
        @(negedge CLK);
        check("bready_after_rst", 64'(m_axi_bready), 64'(1));
        tick();

        // Single burst
        single_burst("single");

        // Command before data, data trickling in one beat per 3 cycles
        push_cmd(8'd64, 32'h0000_0000);
        saw = 1'b0;
        for (int i = 0; i < 64; i++) begin
            push_data($urandom, 4'($urandom));
            if (i < 63) begin
                repeat (2) begin
                    @(negedge CLK);
                    saw |= m_axi_awvalid;
                    tick();
                end
            end
        end
        check("cmd_first_no_early_aw", 64'(saw), 64'(0));
        expect_aw_after("cmd_first_aw_latency", 2);
        wait_idle("cmd_first");

        // Random backpressure on AW and W over three bursts
        aw_pct = 50;
        w_pct  = 50;
        for (int i = 0; i < 192; i++) push_data($urandom, 4'($urandom));
        for (int b = 0; b < 3; b++) push_cmd(8'd64, $urandom);
        wait_idle("backpressure");
        aw_pct = 100;
        w_pct  = 100;

        // Outstanding limit
        aw0 = aw_count;
        b_budget = 0;
        for (int i = 0; i < 40; i++) push_data($urandom, 4'($urandom));
        for (int k = 0; k < 5; k++) push_cmd(8'd8, $urandom);
        repeat (100) @(negedge CLK);
        check("limit_aw_count", 64'(aw_count - aw0), 64'(4));
        check("limit_awvalid_low", 64'(m_axi_awvalid), 64'(0));
        b0 = b_count;
        b_budget = 1;
        n = 0;
        while (b_count == b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("limit_b_seen", 64'(b_count - b0), 64'(1));
        n = 0;
        while (!m_axi_awvalid && n < 6) begin
            @(negedge CLK);
            n++;
        end
        check("limit_aw_after_b", 64'(m_axi_awvalid && n <= 2), 64'(1));
        b_budget = 1000000;
        wait_idle("limit");

        // Error flags: overflow, zero-length command, error response
        for (int i = 0; i < 256; i++) push_data(32'(i), 4'hF);
        @(negedge CLK);
        check("overflow_at_256", 64'(overflow), 64'(0));
        push_data(32'(256), 4'hF);
        @(negedge CLK);
        check("overflow_at_257", 64'(overflow), 64'(1));
        aw0 = aw_count;
        push_cmd(8'd0, 32'h0000_0100);
        @(negedge CLK);
        check("cmd_err_set", 64'(cmd_err), 64'(1));
        repeat (5) @(negedge CLK);
        check("zero_len_no_aw", 64'({m_axi_awvalid, 32'(aw_count - aw0)}), 64'(0));
        check("zero_len_not_busy", 64'(busy), 64'(0));
        check("resp_err_clear", 64'(resp_err), 64'(0));
        b_resp_val = 2'b10;
        push_cmd(8'd255, 32'h0000_2000);
        wait_idle("full_burst");
        check("resp_err_set", 64'(resp_err), 64'(1));
        check("overflow_sticky", 64'(overflow), 64'(1));
        b_resp_val = 2'b00;

        // Reset in the middle of a burst
        w0 = w_count;
        for (int i = 0; i < 64; i++) push_data($urandom, 4'($urandom));
        push_cmd(8'd64, $urandom);
        n = 0;
        while (w_count - w0 < 10 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("mid_reset_reached_beat10", 64'(w_count - w0), 64'(10));
        @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        pool.delete();
        pend.delete();
        accepted = 0;
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("mid_reset_valids", 64'({m_axi_wvalid, m_axi_awvalid, m_axi_wlast}), 64'(0));
        check("mid_reset_status", 64'({busy, overflow, cmd_err, resp_err}), 64'(0));
        tick();
        RST = 1'b0;
        tick();
        tick();
        single_burst("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_write_bridge.md
# dram_write_bridge

Write-side responder for the packed DRAM write port used by the frame compositing blocks (`data_in`/`data_we`, `ctrl_in`/`ctrl_we`). It buffers 36-bit write beats (strobe + data) and 40-bit commands (length + byte address) in two independent FIFOs. It converts each command into one AXI4 INCR write burst toward the memory controller. A burst is issued only once its full payload is buffered, so the W channel never starves mid-burst.

## Interface
Parameters:
- `DATA_AW`, default 8: log2 of data FIFO depth (256 beats).
- `CMD_AW`, default 4: log2 of command FIFO depth (16 commands).
- `MAX_OUTSTANDING`, default 4: maximum bursts with an AW handshake done and B still pending.

Ports:
- `CLK`, in, 1: clock.
- `RST`, in, 1: synchronous, active-high reset.
- `data_in`, in, 36: `[35:32]` byte strobe, `[31:0]` data.
- `data_we`, in, 1: push `data_in`.
- `ctrl_in`, in, 40: `[39:32]` beat count `len`, `[31:0]` byte address.
- `ctrl_we`, in, 1: push `ctrl_in`.
- `m_axi_awaddr`, out, 32; `m_axi_awlen`, out, 8; `m_axi_awsize`, out, 3 (constant 3'd2); `m_axi_awburst`, out, 2 (constant 2'b01).
- `m_axi_awvalid`, out, 1; `m_axi_awready`, in, 1.
- `m_axi_wdata`, out, 32; `m_axi_wstrb`, out, 4; `m_axi_wlast`, out, 1; `m_axi_wvalid`, out, 1; `m_axi_wready`, in, 1.
- `m_axi_bresp`, in, 2; `m_axi_bvalid`, in, 1; `m_axi_bready`, out, 1.
- `busy`, out, 1: command FIFO non-empty, FSM not in IDLE, or outstanding count ≠ 0.
- `overflow`, out, 1: sticky; a push was dropped because its FIFO was full.
- `cmd_err`, out, 1: sticky; a command with `len`=0 was received.
- `resp_err`, out, 1: sticky; a B response had `bresp` ≠ OKAY.

## Operation
- Data FIFO and command FIFO are show-ahead (first-word-fall-through), each with an occupancy counter.
- A push to a full FIFO is dropped and sets `overflow`. Fullness is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even if a pop occurs in the same cycle.
- A command with `len`=0 is never enqueued; it sets `cmd_err`.
- `awaddr` = `ctrl_in[31:2]`,2'b00 (byte address forced word-aligned).
- `awlen` = `len`-1.
- Bursts are not split at 4 KB boundaries; producers guarantee compliance.
- FSM:
  - IDLE → AW when the command FIFO is non-empty, data occupancy ≥ head `len`, and outstanding < `MAX_OUTSTANDING`. On this transition the head command is popped and `awaddr`/`awlen` are registered.
  - AW: `awvalid`=1. On `awready` → W, outstanding +1, beat counter loaded with `len`.
  - W: `wvalid`=1 while beats remain. Each `wvalid&wready` pops one data entry. `wlast`=1 on the final beat. The final handshake → IDLE.
- W data never begins before the AW handshake completes.
- B channel: `bready`=1 whenever not in reset.
  - Each `bvalid` decrements outstanding.
  - When a B response and an AW handshake occur in the same cycle, outstanding is unchanged.
- Data pushed with no matching command remains buffered indefinitely.
- Beat order equals push order; beats are never reordered, duplicated, or lost once accepted.

## Timing
- Reset values:
  - `awvalid`, `wvalid`, `wlast`, `bready` = 0.
  - `awaddr`, `awlen`, `wdata`, `wstrb` = 0.
  - `busy`, `overflow`, `cmd_err`, `resp_err` = 0.
  - FIFOs empty, outstanding = 0, FSM in IDLE.
- Reset mid-burst: all outputs return to their reset values on the next edge and buffered data is discarded. The downstream interconnect is reset together with this block.
- Push → visible in occupancy: 1 cycle.
- `ctrl_we` at cycle t, with payload already buffered, `awready`=1 → `awvalid` high at t+2.
- With `wready` held high, a `len`-beat burst occupies exactly `len` consecutive cycles. The first beat is the cycle after the AW handshake.
- While `wvalid`=1 and `wready`=0, `wdata`, `wstrb`, and `wlast` hold stable.
- While `awvalid`=1, the AW fields hold stable until `awready`.
- Back-to-back bursts: IDLE costs 1 cycle between the last W beat and the next `awvalid`.

## Test plan
- Single burst: 64 pushes of data `i` with strobe 0xF, then ctrl {64, 0x1000_0004}, all readies high → `awaddr`=0x1000_0004, `awlen`=63, `awsize`=2, `awburst`=1. 64 beats with data 0..63 in order, `wlast` only on beat 64, `busy` low after B.
- Command before data: ctrl {64, 0x0} first, data pushed one per 3 cycles → `awvalid` stays 0 until the 64th beat is buffered, then asserts 2 cycles later.
- W backpressure: random `wready` (50%) over 3 bursts of 64 → 192 beats with no gaps in sequence, no duplicates, fields stable during stalls.
- Outstanding limit: `bvalid` held low, 5 commands with data ready → exactly 4 AW handshakes. Pulse one B response → 5th `awvalid` within 2 cycles.
- Error flags: 257 data pushes without ctrl → occupancy 256, `overflow`=1. Ctrl {0, 0x100} → `cmd_err`=1, no AW. B response with `bresp`=2 → `resp_err`=1.
- Reset mid-burst: assert RST after beat 10 of 64 → next cycle `wvalid`=0, `awvalid`=0, `busy`=0, all flags 0. A fresh single-burst sequence then completes as in the first scenario.
